// File: rtl/pipe_pkg.sv
// Shared types and field layout for the elastic pipeline-stage register.
// Optional skid buffer is selected with PIPE_STAGE_SKID_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    localparam int PIPE_CTRL_W = 9;
    localparam int PIPE_DATA_W = 178;

    // Control-field bit positions (EXE_CMD occupies four bits from its LSB).
    localparam int CTRL_WB_EN       = 0;
    localparam int CTRL_MEM_R       = 1;
    localparam int CTRL_MEM_W       = 2;
    localparam int CTRL_B           = 3;
    localparam int CTRL_S           = 4;
    localparam int CTRL_EXE_CMD_LSB = 5;

    // Payload field LSB positions.
    localparam int DATA_PC_LSB     = 0;
    localparam int DATA_VAL_RN_LSB = 32;
    localparam int DATA_VAL_RM_LSB = 64;
    localparam int DATA_IMM_LSB    = 96;
    localparam int DATA_SHIFT_LSB  = 97;
    localparam int DATA_IMM24_LSB  = 109;
    localparam int DATA_DEST_LSB   = 133;
    localparam int DATA_INSTR_LSB  = 137;
    localparam int DATA_SRC1_LSB   = 169;
    localparam int DATA_SRC2_LSB   = 173;
    localparam int DATA_CARRY_LSB  = 177;

    function automatic logic [1:0] occupancy_of(input state_e s);
        case (s)
            FULL:    return 2'd1;
            SKID:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot of the pipeline-stage register: valid, control and payload.
// Flush beats load, load beats clear; PIPE_STAGE_SKID_EN decides how many are used.
module pipe_slot #(
    parameter int CTRL_W     = 9,
    parameter int DATA_W     = 178,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // With CLEAR_DATA=0 a flush leaves the payload untouched to save toggling.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA) data_d = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with flush.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = PIPE_CTRL_W,
    parameter int DATA_W     = PIPE_DATA_W,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e            state_q, state_d;
    logic              in_fire, out_fire;
    logic              main_load, main_clear;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] main_data, main_data_in;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_load, skid_clear, main_from_skid;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready     = ~skid_valid;
    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : in_data;
`else
    assign in_ready     = out_ready | ~out_valid;
    assign main_ctrl_in = in_ctrl;
    assign main_data_in = in_data;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Flush overrides every transition; the FSM never asserts a load during it.
    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
`ifdef PIPE_STAGE_SKID_EN
                        state_d   = SKID;
                        skid_load = 1'b1;
`endif
                    end else if (out_fire) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                SKID: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (out_fire) begin
                        state_d        = FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CLEAR_DATA(CLEAR_DATA)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush),
        .load_i (main_load),
        .clear_i(main_clear),
        .ctrl_i (main_ctrl_in),
        .data_i (main_data_in),
        .valid_o(main_valid),
        .ctrl_o (main_ctrl),
        .data_o (main_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CLEAR_DATA(CLEAR_DATA)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .ctrl_i (in_ctrl),
        .data_i (in_data),
        .valid_o(skid_valid),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data)
    );
`endif

    // Bubbles carry zero control so downstream enables cannot fire.
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = occupancy_of(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; expectations follow PIPE_STAGE_SKID_EN.
// A second instance covers CLEAR_DATA=0.
module tb_pipe_stage_reg;

    localparam int CW = 9;
    localparam int DW = 178;

    typedef struct {
        logic        inValid;
        logic [31:0] inData;
        logic        outReady;
        logic        flush;
        logic        expValid;
        logic [31:0] expData;
        logic        chkData;
        logic [1:0]  expOcc;
        logic        expReady;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [CW-1:0] inCtrl = '0;
    logic [DW-1:0] inData = '0;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [CW-1:0] outCtrl;
    logic [DW-1:0] outData;
    logic [1:0]    occupancy;

    logic          d2Flush = 1'b0;
    logic          d2InValid = 1'b0;
    logic          d2InReady;
    logic [CW-1:0] d2InCtrl = '0;
    logic [15:0]   d2InData = '0;
    logic          d2OutValid;
    logic          d2OutReady = 1'b0;
    logic [CW-1:0] d2OutCtrl;
    logic [15:0]   d2OutData;
    logic [1:0]    d2Occupancy;

    int passCount  = 0;
    int checkCount = 0;

    vec_t streamVec [10];
`ifdef PIPE_STAGE_SKID_EN
    vec_t skidVec [7];
`else
    vec_t nsVec [7];
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(16), .CLEAR_DATA(1'b0)) dut2 (
        .clk(clk), .rst(rst), .flush(d2Flush),
        .in_valid(d2InValid), .in_ready(d2InReady), .in_ctrl(d2InCtrl), .in_data(d2InData),
        .out_valid(d2OutValid), .out_ready(d2OutReady), .out_ctrl(d2OutCtrl), .out_data(d2OutData),
        .occupancy(d2Occupancy)
    );

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        inValid  = v;
        inData   = DW'(d);
        inCtrl   = v ? 9'h1FF : 9'h000;
        outReady = ordy;
        flush    = fl;
    endtask

    task automatic checkState(input string tag, input logic ev, input logic [31:0] ed,
                              input logic chkData, input logic [1:0] eocc, input logic erdy);
        checkOutput({tag, " out_valid"}, 256'(outValid), 256'(ev));
        checkOutput({tag, " out_ctrl"}, 256'(outCtrl), ev ? 256'h1FF : 256'h0);
        if (chkData) checkOutput({tag, " out_data"}, 256'(outData), 256'(ed));
        checkOutput({tag, " occupancy"}, 256'(occupancy), 256'(eocc));
        checkOutput({tag, " in_ready"}, 256'(inReady), 256'(erdy));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v.inValid, v.inData, v.outReady, v.flush);
        @(negedge clk);
        checkState(tag, v.expValid, v.expData, v.chkData, v.expOcc, v.expReady);
        nextCycle();
    endtask

    initial begin
        // Streaming: beats 1..8 back to back, then drain.
        for (int i = 0; i < 8; i++) begin
            streamVec[i] = '{1'b1, 32'(i + 1), 1'b1, 1'b0,
                             (i != 0), 32'(i), (i != 0), (i != 0) ? 2'd1 : 2'd0, 1'b1};
        end
        streamVec[8] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 2'd1, 1'b1};
        streamVec[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1};
`ifdef PIPE_STAGE_SKID_EN
        skidVec[0] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1};
        skidVec[1] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1, 1'b1};
        skidVec[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd2, 1'b0};
        skidVec[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd2, 1'b0};
        skidVec[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hA, 1'b1, 2'd2, 1'b0};
        skidVec[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB, 1'b1, 2'd1, 1'b1};
        skidVec[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1};
`else
        nsVec[0] = '{1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1};
        nsVec[1] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1, 1'b0};
        nsVec[2] = '{1'b1, 32'hB, 1'b1, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1, 1'b1};
        nsVec[3] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hB, 1'b1, 2'd1, 1'b0};
        nsVec[4] = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 1'b1, 2'd1, 1'b1};
        nsVec[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 2'd1, 1'b1};
        nsVec[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1};
`endif

        // Reset state before any clock edge.
        #2;
        checkState("reset", 1'b0, 32'h0, 1'b1, 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();

        for (int i = 0; i < 10; i++) runVec($sformatf("stream[%0d]", i), streamVec[i]);

`ifdef PIPE_STAGE_SKID_EN
        for (int i = 0; i < 7; i++) runVec($sformatf("skid[%0d]", i), skidVec[i]);

        // Flush while two beats are held and a third is offered.
        applyStimulus(1'b1, 32'hD, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'hE, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
        @(negedge clk);
        checkState("preflush", 1'b1, 32'hD, 1'b1, 2'd2, 1'b0);
        nextCycle();
`else
        for (int i = 0; i < 7; i++) runVec($sformatf("noskid[%0d]", i), nsVec[i]);

        // Flush while one beat is held and another is offered.
        applyStimulus(1'b1, 32'hD, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
        @(negedge clk);
        checkState("preflush", 1'b1, 32'hD, 1'b1, 2'd1, 1'b0);
        nextCycle();
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkState("postflush", 1'b0, 32'h0, 1'b1, 2'd0, 1'b1);
        nextCycle();
        @(negedge clk);
        checkState("postflush+1", 1'b0, 32'h0, 1'b1, 2'd0, 1'b1);
        nextCycle();

        // Asynchronous reset mid-stream with the stage holding beats.
        applyStimulus(1'b1, 32'hF, 1'b0, 1'b0);
        nextCycle();
`ifdef PIPE_STAGE_SKID_EN
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkState("prereset", 1'b1, 32'hF, 1'b1, 2'd2, 1'b0);
`else
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkState("prereset", 1'b1, 32'hF, 1'b1, 2'd1, 1'b0);
`endif
        nextCycle();
        #2;
        rst = 1'b1;
        #1;
        checkState("asyncreset", 1'b0, 32'h0, 1'b1, 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();

        // CLEAR_DATA=0 instance: flush keeps the payload.
        d2InValid  = 1'b1;
        d2InData   = 16'h0055;
        d2InCtrl   = 9'h1FF;
        d2OutReady = 1'b0;
        nextCycle();
        d2InValid = 1'b0;
        d2InCtrl  = '0;
        d2InData  = '0;
        @(negedge clk);
        checkOutput("keep out_valid", 256'(d2OutValid), 256'h1);
        checkOutput("keep out_data", 256'(d2OutData), 256'h55);
        d2Flush = 1'b1;
        nextCycle();
        d2Flush = 1'b0;
        @(negedge clk);
        checkOutput("keep flushed out_valid", 256'(d2OutValid), 256'h0);
        checkOutput("keep flushed out_ctrl", 256'(d2OutCtrl), 256'h0);
        checkOutput("keep flushed out_data", 256'(d2OutData), 256'h55);
        checkOutput("keep flushed occupancy", 256'(d2Occupancy), 256'h0);
        checkOutput("keep flushed in_ready", 256'(d2InReady), 256'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
